// File: rtl/fetch_ctrl_if.sv
// fetch_ctrl_if: handshake and shift-register signals between fetch_ctrl (master) and its environment (slave)
interface fetch_ctrl_if #(parameter int BURST_W = 8);
  logic               start;
  logic [BURST_W-1:0] burst_len;
  logic               abort;
  logic               serial_valid;
  logic               fetch_o;
  logic               shift_en;
  logic               done_word;
  logic [31:0]        shifted_word;
  logic [31:0]        word_out;
  logic               word_valid;
  logic               word_ready;
  logic               busy;
  logic               burst_done;
  logic [BURST_W-1:0] words_sent;
  logic               timeout_err;
  modport master (
    input  start, burst_len, abort, serial_valid, done_word, shifted_word, word_ready,
    output fetch_o, shift_en, word_out, word_valid, busy, burst_done, words_sent, timeout_err
  );
  modport slave (
    output start, burst_len, abort, serial_valid, done_word, shifted_word, word_ready,
    input  fetch_o, shift_en, word_out, word_valid, busy, burst_done, words_sent, timeout_err
  );
endinterface

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: burst fetch FSM moving shift-register words onto a valid/ready port; FETCH_TIMEOUT_EN adds a FETCH dwell timeout
module fetch_ctrl #(
  parameter int BURST_W        = 8,
  parameter int TIMEOUT_CYCLES = 256
) (
  input logic         clk,
  input logic         reset,
  fetch_ctrl_if.master bus
);
  typedef enum logic [1:0] {IDLE, FETCH, PUSH, DONE} state_t;
  state_t             state;
  logic [BURST_W-1:0] len;
  logic [BURST_W-1:0] words_sent;
  logic [BURST_W-1:0] ws_next;
  logic [31:0]        word_out;
  logic               word_valid;
`ifdef FETCH_TIMEOUT_EN
  localparam int TC_W = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TC_W-1:0] tcnt;
  logic            timeout_err;
  assign bus.timeout_err = timeout_err;
`else
  assign bus.timeout_err = 1'b0;
`endif
  assign ws_next        = words_sent + BURST_W'(1);
  assign bus.fetch_o    = state == FETCH;
  assign bus.shift_en   = bus.fetch_o & bus.serial_valid & ~bus.done_word;
  assign bus.busy       = state != IDLE;
  assign bus.burst_done = state == DONE;
  assign bus.word_out   = word_out;
  assign bus.word_valid = word_valid;
  assign bus.words_sent = words_sent;
  // State sequencing with abort taking priority over capture and handshake
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      len        <= '0;
      word_out   <= '0;
      word_valid <= 1'b0;
      words_sent <= '0;
`ifdef FETCH_TIMEOUT_EN
      tcnt        <= '0;
      timeout_err <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (bus.start && bus.burst_len != '0) begin
          len        <= bus.burst_len;
          words_sent <= '0;
          state      <= FETCH;
`ifdef FETCH_TIMEOUT_EN
          tcnt        <= '0;
          timeout_err <= 1'b0;
`endif
        end
        FETCH: if (bus.abort) begin
          state <= IDLE;
        end else if (bus.done_word) begin
          word_out   <= bus.shifted_word;
          word_valid <= 1'b1;
          state      <= PUSH;
        end
`ifdef FETCH_TIMEOUT_EN
        else if (tcnt == TC_W'(TIMEOUT_CYCLES - 1)) begin
          state       <= IDLE;
          timeout_err <= 1'b1;
        end else begin
          tcnt <= tcnt + TC_W'(1);
        end
`endif
        PUSH: if (bus.abort) begin
          state      <= IDLE;
          word_valid <= 1'b0;
        end else if (bus.word_ready) begin
          word_valid <= 1'b0;
          words_sent <= ws_next;
          state      <= ws_next == len ? DONE : FETCH;
`ifdef FETCH_TIMEOUT_EN
          tcnt <= '0;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed self-checking bench for fetch_ctrl
module tb_fetch_ctrl;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;
  fetch_ctrl_if #(.BURST_W(8)) bus ();
  fetch_ctrl #(.BURST_W(8), .TIMEOUT_CYCLES(16)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.master)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask
  initial begin
    reset = 1'b1;
    bus.start = 0; bus.burst_len = 0; bus.abort = 0; bus.serial_valid = 0;
    bus.done_word = 0; bus.shifted_word = 0; bus.word_ready = 0;
    tick(); tick();
    reset = 1'b0;
    chk("rst_busy", bus.busy, 0);
    chk("rst_fetch", bus.fetch_o, 0);
    chk("rst_shift", bus.shift_en, 0);
    chk("rst_valid", bus.word_valid, 0);
    chk("rst_wout", bus.word_out, 0);
    chk("rst_ws", bus.words_sent, 0);
    chk("rst_done", bus.burst_done, 0);
    chk("rst_terr", bus.timeout_err, 0);
    // three-word burst, always ready
    bus.serial_valid = 1; bus.word_ready = 1; bus.start = 1; bus.burst_len = 3;
    tick();
    bus.start = 0;
    chk("b3_fetch", bus.fetch_o, 1);
    chk("b3_busy", bus.busy, 1);
    chk("b3_shift", bus.shift_en, 1);
    for (int i = 0; i < 3; i++) begin
      bus.done_word = 1; bus.shifted_word = 32'h100 + i;
      #1;
      chk("b3_shift_dw", bus.shift_en, 0);
      tick();
      bus.done_word = 0;
      chk("b3_push_fetch", bus.fetch_o, 0);
      chk("b3_push_valid", bus.word_valid, 1);
      chk("b3_push_wout", bus.word_out, 32'h100 + i);
      tick();
      chk("b3_after_valid", bus.word_valid, 0);
      chk("b3_after_ws", bus.words_sent, i + 1);
      chk("b3_after_fetch", bus.fetch_o, i < 2 ? 1 : 0);
      chk("b3_after_done", bus.burst_done, i == 2 ? 1 : 0);
    end
    tick();
    chk("b3_idle_done", bus.burst_done, 0);
    chk("b3_idle_busy", bus.busy, 0);
    chk("b3_idle_ws", bus.words_sent, 3);
    // single word with stalled ready
    bus.word_ready = 0; bus.start = 1; bus.burst_len = 1;
    tick();
    bus.start = 0; bus.done_word = 1; bus.shifted_word = 32'hDEADBEEF;
    tick();
    bus.done_word = 0; bus.shifted_word = 32'h0;
    for (int k = 0; k < 5; k++) begin
      chk("stall_valid", bus.word_valid, 1);
      chk("stall_wout", bus.word_out, 32'hDEADBEEF);
      chk("stall_fetch", bus.fetch_o, 0);
      chk("stall_ws", bus.words_sent, 0);
      tick();
    end
    bus.word_ready = 1;
    chk("stall_last_valid", bus.word_valid, 1);
    chk("stall_last_wout", bus.word_out, 32'hDEADBEEF);
    tick();
    chk("stall_hs_valid", bus.word_valid, 0);
    chk("stall_hs_done", bus.burst_done, 1);
    chk("stall_hs_ws", bus.words_sent, 1);
    tick();
    chk("stall_idle_done", bus.burst_done, 0);
    // shift_en follows serial_valid while fetching
    bus.start = 1; bus.burst_len = 1;
    tick();
    bus.start = 0;
    for (int k = 0; k < 4; k++) begin
      bus.serial_valid = (k % 2) == 0;
      #1;
      chk("tog_shift", bus.shift_en, (k % 2) == 0 ? 1 : 0);
      tick();
    end
    bus.serial_valid = 1; bus.done_word = 1; bus.shifted_word = 32'h55;
    #1;
    chk("tog_shift_dw", bus.shift_en, 0);
    tick();
    bus.done_word = 0;
    chk("tog_push_shift", bus.shift_en, 0);
    tick(); tick();
    chk("tog_idle", bus.busy, 0);
    // abort coincident with done_word
    bus.start = 1; bus.burst_len = 4;
    tick();
    bus.start = 0; bus.done_word = 1; bus.shifted_word = 32'hA1;
    tick();
    bus.done_word = 0;
    tick();
    chk("ab_ws1", bus.words_sent, 1);
    chk("ab_fetch", bus.fetch_o, 1);
    bus.done_word = 1; bus.shifted_word = 32'hA2; bus.abort = 1;
    tick();
    bus.done_word = 0; bus.abort = 0;
    chk("ab_busy", bus.busy, 0);
    chk("ab_valid", bus.word_valid, 0);
    chk("ab_ws", bus.words_sent, 1);
    chk("ab_done", bus.burst_done, 0);
    tick();
    chk("ab_done2", bus.burst_done, 0);
    // zero-length start and start while busy
    bus.start = 1; bus.burst_len = 0;
    tick();
    chk("z_busy", bus.busy, 0);
    chk("z_ws", bus.words_sent, 1);
    bus.burst_len = 2;
    tick();
    chk("sb_fetch", bus.fetch_o, 1);
    chk("sb_ws", bus.words_sent, 0);
    bus.burst_len = 5;
    tick();
    chk("sb_still_fetch", bus.fetch_o, 1);
    chk("sb_still_busy", bus.busy, 1);
    bus.start = 0;
    for (int i = 0; i < 2; i++) begin
      bus.done_word = 1; bus.shifted_word = 32'hB0 + i;
      tick();
      bus.done_word = 0;
      tick();
    end
    chk("sb_done", bus.burst_done, 1);
    chk("sb_ws2", bus.words_sent, 2);
    tick();
    // long FETCH dwell: timeout only when the feature is built in
    bus.serial_valid = 0; bus.start = 1; bus.burst_len = 1;
    tick();
    bus.start = 0;
    for (int k = 1; k < 16; k++) tick();
    chk("to_fetch16", bus.fetch_o, 1);
    tick();
`ifdef FETCH_TIMEOUT_EN
    chk("to_busy", bus.busy, 0);
    chk("to_err", bus.timeout_err, 1);
    chk("to_done", bus.burst_done, 0);
    bus.start = 1;
    tick();
    bus.start = 0;
    chk("to_err_clr", bus.timeout_err, 0);
`else
    chk("to_busy", bus.busy, 1);
    chk("to_err", bus.timeout_err, 0);
`endif
    // reset mid-burst discards the in-flight word
    bus.abort = 1;
    tick();
    bus.abort = 0; bus.start = 1; bus.burst_len = 2; bus.word_ready = 0;
    tick();
    bus.start = 0; bus.done_word = 1; bus.shifted_word = 32'hC0FFEE;
    tick();
    bus.done_word = 0;
    chk("mr_valid_pre", bus.word_valid, 1);
    reset = 1; bus.start = 1; bus.abort = 1; bus.serial_valid = 1;
    tick();
    chk("mr_busy", bus.busy, 0);
    chk("mr_fetch", bus.fetch_o, 0);
    chk("mr_shift", bus.shift_en, 0);
    chk("mr_valid", bus.word_valid, 0);
    chk("mr_wout", bus.word_out, 0);
    chk("mr_ws", bus.words_sent, 0);
    chk("mr_terr", bus.timeout_err, 0);
    reset = 0; bus.start = 0; bus.abort = 0;
    tick();
    chk("mr_idle", bus.busy, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL have parameter BURST_W, default 8, width of burst_len and words_sent.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 256, maximum FETCH dwell in cycles (used only with FETCH_TIMEOUT_EN).
REQ-003 SHALL have port clk  input  1  clock; all logic on posedge.
REQ-004 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port start  input  1  request to begin a burst; sampled only in IDLE.
REQ-006 SHALL have port burst_len  input  BURST_W  words in burst; latched on accepted start.
REQ-007 SHALL have port abort  input  1  cancel current burst.
REQ-008 SHALL have port serial_valid  input  1  serial bit present on serial line this cycle.
REQ-009 SHALL have port fetch_o  output  1  high while in FETCH; drives shift register fetch input.
REQ-010 SHALL have port shift_en  output  1  shift strobe to shift register.
REQ-011 SHALL have port done_word  input  1  shift register has 32 bits.
REQ-012 SHALL have port shifted_word  input  32  parallel word from shift register.
REQ-013 SHALL have port word_out  output  32  captured word.
REQ-014 SHALL have port word_valid / word_ready  output / input  1 / 1  valid-ready handshake for word_out.
REQ-015 SHALL have ports busy  output  1 (state != IDLE); burst_done  output  1 (one-cycle pulse); words_sent  output  BURST_W (words accepted this burst); timeout_err  output  1 (sticky timeout flag).

Function
REQ-016 SHALL implement Moore FSM with states IDLE, FETCH, PUSH, DONE.
REQ-017 IDLE: start=1 and burst_len!=0 -> latch burst_len, clear words_sent and timeout_err, go to FETCH; start with burst_len=0 ignored.
REQ-018 fetch_o SHALL be 1 exactly when state is FETCH (registered state decode, no combinational input path).
REQ-019 shift_en SHALL equal fetch_o AND serial_valid AND NOT done_word.
REQ-020 FETCH with done_word=1 -> capture shifted_word into word_out, set word_valid, go to PUSH at same edge.
REQ-021 PUSH: word_out and word_valid held stable until word_ready=1; handshake increments words_sent.
REQ-022 PUSH handshake -> DONE if words_sent+1 equals latched length, else FETCH; fetch_o low at least one cycle between words so shift register clears its count.
REQ-023 word_valid SHALL deassert on the cycle following the handshake.
REQ-024 DONE: burst_done=1 for exactly one cycle, then IDLE; words_sent holds final count until next accepted start.
REQ-025 abort=1 in any non-IDLE state -> IDLE next edge, word_valid cleared, no burst_done; abort takes priority over done_word and handshake in the same cycle.
REQ-026 start outside IDLE SHALL be ignored; burst_len changes after acceptance SHALL have no effect.
REQ-027 words_sent SHALL not wrap; maximum burst is 2^BURST_W-1 words.

Reset
REQ-028 reset SHALL force state IDLE, word_out=0, word_valid=0, words_sent=0, burst_done=0, timeout_err=0, timeout counter=0; fetch_o and shift_en 0 the following cycle.
REQ-029 reset mid-burst SHALL discard the in-flight word without handshake; reset overrides abort and start.

Configuration
REQ-030 With FETCH_TIMEOUT_EN defined: counter clears on FETCH entry, increments each FETCH cycle; reaching TIMEOUT_CYCLES-1 without done_word -> IDLE, timeout_err=1 (sticky), no burst_done.
REQ-031 Without FETCH_TIMEOUT_EN: no counter, FETCH waits indefinitely, timeout_err tied 0; port list unchanged.

Verification
REQ-032 burst_len=3, serial_valid=1 constant, word_ready=1 -> three words with fetch_o low one cycle between each, words_sent=3, one burst_done pulse.
REQ-033 burst_len=1, shifted_word=0xDEADBEEF, word_ready low 5 cycles -> word_valid held 5+1 cycles, word_out stable 0xDEADBEEF, fetch_o low throughout.
REQ-034 serial_valid toggling 1/0 in FETCH -> shift_en mirrors serial_valid, 0 once done_word=1.
REQ-035 abort in same cycle as done_word (burst_len=4) -> IDLE next cycle, word_valid=0, words_sent unchanged, no burst_done.
REQ-036 start with burst_len=0, and start while busy -> state unchanged, busy unchanged.
REQ-037 FETCH_TIMEOUT_EN, TIMEOUT_CYCLES=16, serial_valid=0 -> IDLE after 16 FETCH cycles, timeout_err=1 until next accepted start; reset mid-FETCH clears all outputs next cycle.
